hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall scheduler for the 5-stage core: it decides every cycle whether FETCH/DECODE advance, hold, or flush. It also decides whether EXECUTE receives a bubble and whether the whole pipe freezes on a slow data-memory access. It sits beside DECODE, consumes the DECODE/EXECUTE/MEMORY control fields produced by `CPU_ctrl`, and complements `bypass_ctrl`: forwarding covers ALU results, and this block covers load-use, taken branches and memory wait states.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive memory wait cycles before the error trap.
- `CNT_W`, default 16: width of the performance counters.
- `CLK` in 1: the only clock, rising edge.
- `RESET` in 1: asynchronous, active-high.
- `DECODE_RS`, `DECODE_RT` in 5 each: source registers of the instruction in DECODE.
- `decode_uses_rt` in 1: the DECODE instruction reads rt (R-format, SW, BEQ, BNE).
- `EXECUTE_RD` in 5: destination register of the instruction in EXECUTE.
- `is_mem_read_ex` in 1: EXECUTE holds an LW.
- `BRANCH_OP_EX` in 2: branch op in EXECUTE (0 none, `BEQ`, `BNE`).
- `alu_zero_ex` in 1: ALU zero flag in EXECUTE.
- `mem_req` in 1: MEMORY stage holds an LW or SW.
- `mem_ready` in 1: data memory completes this cycle.
- `pc_write` out 1: PC may update.
- `if_id_write` out 1: IF/ID register may load.
- `if_id_flush` out 1: IF/ID loads a NOP.
- `id_ex_bubble` out 1: ID/EX loads all-zero controls.
- `pipe_hold` out 1: freeze ID/EX, EX/MEM and MEM/WB.
- `pc_sel_branch` out 1: PC takes the branch target.
- `mem_error` out 1: sticky timeout trap.
- `STALL_COUNT`, `FLUSH_COUNT` out `CNT_W` each: saturating performance counters.

## Operation
- FSM states: `RUN`, `MEM_WAIT`, `ERROR`. The reset state is `RUN`.
- `taken` = (`BRANCH_OP_EX`==`BEQ` & `alu_zero_ex`) | (`BRANCH_OP_EX`==`BNE` & !`alu_zero_ex`).
- `load_use` = `is_mem_read_ex` & `EXECUTE_RD`!=0 & (`EXECUTE_RD`==`DECODE_RS` | (`decode_uses_rt` & `EXECUTE_RD`==`DECODE_RT`)).
- `mem_stall` = `mem_req` & !`mem_ready`.
- Outputs are combinational from the state and current inputs. The first applicable rule in the list below decides them; all signals not named take their defaults.
- Defaults: `pc_write`=1, `if_id_write`=1, all other controls 0.
  1. `ERROR`: `pc_write`=0, `if_id_write`=0, `pipe_hold`=1, `mem_error`=1.
  2. `mem_stall` in `RUN` or `MEM_WAIT`: `pc_write`=0, `if_id_write`=0, `pipe_hold`=1. Branch and load-use are ignored because EXECUTE is frozen and they are re-evaluated next cycle.
  3. `taken`: `pc_sel_branch`=1, `if_id_flush`=1, `id_ex_bubble`=1. A coincident `load_use` is ignored because the dependent instruction is flushed.
  4. `load_use`: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1.
- Transitions:
  - `RUN` goes to `MEM_WAIT` on `mem_stall`.
  - `MEM_WAIT` goes to `RUN` on `mem_ready`.
  - `MEM_WAIT` goes to `ERROR` when the wait counter reaches `MEM_TIMEOUT`.
  - `ERROR` is left only by reset.
- Wait counter:
  - Clears on entry to `MEM_WAIT`.
  - Increments each cycle in `MEM_WAIT` with `mem_ready`=0.
  - Its width is clog2(`MEM_TIMEOUT`+1).
- `STALL_COUNT`: +1 every cycle with `pc_write`=0 while not in `ERROR`. It saturates at all-ones.
- `FLUSH_COUNT`: +1 every cycle with `if_id_flush`=1. It saturates at all-ones.

## Timing
- Hazard outputs have zero latency: they take effect in the same cycle the condition is visible. State and counters update on the rising `CLK` edge.
- Load-use produces exactly one bubble. Next cycle the LW is in MEMORY, `is_mem_read_ex`=0, and `bypass_ctrl` forwards from MEMORY.
- A taken branch costs 2 cycles: one flush, plus the instruction already behind it in ID/EX, which is bubbled the same cycle.
- A memory wait of N cycles (`mem_ready` first high in cycle N+1) freezes the pipe for exactly N cycles, then returns to `RUN`.
- `mem_ready`=1 on the first cycle of `mem_req` causes no stall and no state change.
- While `RESET` is high:
  - `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_bubble`=1.
  - `pipe_hold`=0, `pc_sel_branch`=0, `mem_error`=0.
  - Counters are 0 and the state is `RUN`.
- Reset asserted mid-`MEM_WAIT` or in `ERROR` returns the block to `RUN` immediately and clears the counters.

## Structure
- Branch encodings (`BEQ`, `BNE`) come from the existing shared opcode definitions.
- The FSM state encoding and the default `MEM_TIMEOUT` are added to the same shared definitions file.
- One sub-module, `sat_counter` (parameter `W`; inputs `CLK`, `RESET`, `inc`; output `COUNT`), is instantiated twice for the performance counters.

## Test plan
- LW r5 in EXECUTE, DECODE `DECODE_RS`=5 -> one cycle with `pc_write`=0, `id_ex_bubble`=1; next cycle both return to their defaults; `STALL_COUNT`=1.
- Same as above but `EXECUTE_RD`=0, or `DECODE_RT`=5 with `decode_uses_rt`=0 -> no stall.
- `BRANCH_OP_EX`=`BNE`, `alu_zero_ex`=0, with simultaneous load-use -> `pc_sel_branch`=1, `if_id_flush`=1, `pc_write`=1; `FLUSH_COUNT`=1, `STALL_COUNT`=0.
- `mem_req`=1 with `mem_ready` low for 3 cycles and a taken branch in EXECUTE -> `pipe_hold`=1 for 3 cycles with no flush; the 4th cycle performs the flush; `STALL_COUNT`=3.
- `MEM_TIMEOUT`=4, `mem_ready` held low -> `ERROR` entered after 4 `MEM_WAIT` cycles; `mem_error`=1 and sticky; asserting `RESET` clears it asynchronously.
- Force `STALL_COUNT` to saturate with `CNT_W`=4 -> it holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode definitions for the 5-stage core: branch encodings, hazard FSM
// state encoding and the default data-memory timeout.
package hazard_ctrl_pkg;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BEQ     = 2'd1;
  localparam logic [1:0] BNE     = 2'd2;

  localparam int MEM_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         inc,
  output logic [W-1:0] COUNT
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already pinned at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall scheduler: load-use bubbles, taken-branch flushes
// and whole-pipe freeze on slow data-memory accesses, with a timeout trap.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       DECODE_RS,
  input  logic [4:0]       DECODE_RT,
  input  logic             decode_uses_rt,
  input  logic [4:0]       EXECUTE_RD,
  input  logic             is_mem_read_ex,
  input  logic [1:0]       BRANCH_OP_EX,
  input  logic             alu_zero_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             pc_sel_branch,
  output logic             mem_error,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc_s;
  logic              taken_s;
  logic              load_use_s;
  logic              mem_stall_s;
  logic              stall_inc_s;

  assign taken_s     = ((BRANCH_OP_EX == BEQ) && alu_zero_ex) ||
                       ((BRANCH_OP_EX == BNE) && !alu_zero_ex);
  assign load_use_s  = is_mem_read_ex && (EXECUTE_RD != 5'd0) &&
                       ((EXECUTE_RD == DECODE_RS) ||
                        (decode_uses_rt && (EXECUTE_RD == DECODE_RT)));
  assign mem_stall_s = mem_req && !mem_ready;
  assign wait_inc_s  = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (mem_stall_s) begin
          state_d = MEM_WAIT;
          wait_d  = {WAIT_W{1'b0}};
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_inc_s == WAIT_MAX) begin
          state_d = ERROR;
          wait_d  = wait_inc_s;
        end else begin
          wait_d  = wait_inc_s;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
        wait_d  = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Hazard controls: reset pattern first, then the priority chain.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_hold     = 1'b0;
    pc_sel_branch = 1'b0;
    mem_error     = 1'b0;
    if (RESET) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state_q == ERROR) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      mem_error   = 1'b1;
    end else if (mem_stall_s) begin
      // EXECUTE is frozen, so branch/load-use get another look next cycle.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (taken_s) begin
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if (load_use_s) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= RUN;
      wait_q  <= {WAIT_W{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign stall_inc_s = !pc_write && (state_q != ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (stall_inc_s),
    .COUNT (STALL_COUNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (if_id_flush),
    .COUNT (FLUSH_COUNT)
  );

endmodule
